sync_fifo_rd_adapter: RTL and testbench

//  Read-side engine for the synchronous FIFO. Drives the FIFO pop strobe and absorbs the FIFO's 1-cycle registered read data.

---
 rtl/sync_fifo_pkg.sv | 23 ++
 rtl/fifo_skid_buf.sv | 62 ++++++
 rtl/sync_fifo.sv | 76 +++++++
 rtl/sync_fifo_rd_adapter.sv | 139 +++++++++++++
 tb/tb_sync_fifo_rd_adapter.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared types and sizing constants for the synchronous FIFO and its read-side adapter.
// Latency: none; holds only types and constants.
// Backpressure: not applicable.
//
// FIFO_WIDTH / FIFO_SIZE_BITS / FIFO_SIZE describe the default FIFO geometry.
// rd_word_t is one skid-buffer entry: a data word plus its end-of-burst tag.
package sync_fifo_pkg;

    localparam int FIFO_WIDTH     = 16;
    localparam int FIFO_SIZE_BITS = 5;
    localparam int FIFO_SIZE      = 1 << FIFO_SIZE_BITS;

    typedef enum logic {
        RD_IDLE  = 1'b0,
        RD_DRAIN = 1'b1
    } rd_state_e;

    typedef struct packed {
        logic [FIFO_WIDTH-1:0] data;
        logic                  last;
    } rd_word_t;

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry skid buffer of rd_word_t; head is the oldest entry.
// Latency: a pushed word is visible at head the cycle after the push.
// Backpressure: caller must not push when full unless popping the same cycle.
//
// Ports: clk, reset (async, active-high), push/push_word write side,
// pop removes the head, head is the oldest word, occ is occupancy 0..2.
module fifo_skid_buf
    import sync_fifo_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  rd_word_t   push_word,
    input  logic       pop,
    output rd_word_t   head,
    output logic [1:0] occ
);

    rd_word_t   mem_q [2];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] occ_q;
    logic [1:0] occ_d;
    logic       do_push;
    logic       do_pop;

    // Guards keep the pointers coherent even if the caller misbehaves.
    assign do_pop  = pop & (occ_q != 2'd0);
    assign do_push = push & ((occ_q != 2'd2) | do_pop);

    always_comb begin
        occ_d = occ_q;
        case ({do_push, do_pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            occ_q <= occ_d;
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_word;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    assign head = mem_q[rd_ptr_q];
    assign occ  = occ_q;

endmodule

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO with registered read data and an occupancy counter.
// Latency: read data is valid the cycle after an effective pop (rd_en_i & ~empty_o).
// Backpressure: writes while full and reads while empty are silently ignored.
//
// Ports: clk, reset (async, active-high), wr_en_i/wr_data_i write side,
// rd_en_i/rd_data_o read side, empty_o/full_o flags, counter_o occupancy
// (CNT_W bits, so it reads 0 when the FIFO holds DEPTH words).
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH,
    parameter int CNT_W = FIFO_SIZE_BITS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [CNT_W-1:0] counter_o
);

    localparam int DEPTH = 1 << CNT_W;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CNT_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] rd_ptr_q;
    logic [CNT_W:0]   count_q;
    logic [CNT_W:0]   count_d;
    logic [WIDTH-1:0] rd_data_q;
    logic             do_wr;
    logic             do_rd;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == (CNT_W+1)'(DEPTH));
    assign counter_o = count_q[CNT_W-1:0];
    assign rd_data_o = rd_data_q;
    assign do_wr     = wr_en_i & ~full_o;
    assign do_rd     = rd_en_i & ~empty_o;

    always_comb begin
        count_d = count_q;
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + (CNT_W+1)'(1);
            2'b01:   count_d = count_q - (CNT_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_data_q <= '0;
        end else begin
            count_q <= count_d;
            if (do_wr) begin
                wr_ptr_q <= wr_ptr_q + CNT_W'(1);
            end
            if (do_rd) begin
                rd_ptr_q  <= rd_ptr_q + CNT_W'(1);
                rd_data_q <= mem_q[rd_ptr_q];
            end
        end
    end

endmodule

// File: rtl/sync_fifo_rd_adapter.sv
// Read-side engine: waits for a burst threshold, idle timeout or flush, then drains the FIFO as an FWFT stream.
// Latency: first pop the cycle after the trigger; first m_valid two cycles after that pop.
// Backpressure: m_ready low stalls pops through skid credit; words held stable, never dropped.
//
// Ports: clk, reset (async, active-high); FIFO side fifo_empty, fifo_full,
// fifo_counter, fifo_data in and fifo_read pop strobe out; flush pulse;
// stream side m_valid, m_data, m_last out and m_ready in; drain_active mirrors DRAIN.
module sync_fifo_rd_adapter
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH     = FIFO_WIDTH,
    parameter int CNT_W     = FIFO_SIZE_BITS,
    parameter int BURST_MIN = 8,
    parameter int TIMEOUT   = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fifo_empty,
    input  logic             fifo_full,
    input  logic [CNT_W-1:0] fifo_counter,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             fifo_read,
    input  logic             flush,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last,
    input  logic             m_ready,
    output logic             drain_active
);

    localparam int DEPTH  = 1 << CNT_W;
    localparam int LVL_W  = CNT_W + 1;
    localparam int TCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    rd_state_e         state_q;
    rd_state_e         state_d;
    logic [TCNT_W-1:0] tcnt_q;
    logic [TCNT_W-1:0] tcnt_d;
    logic              inflight_q;
    logic              inflight_d;
    logic              last_tag_q;
    logic              last_tag_d;

    logic [LVL_W-1:0]  level;
    logic              pop_is_last;
    logic              start_burst;
    logic              eff_pop;
    logic              hs;
    logic [2:0]        credit;
    rd_word_t          skid_in;
    rd_word_t          skid_head;
    logic [1:0]        skid_occ;

    // The raw counter wraps to 0 at full, so the full flag supplies the MSB.
    assign level       = fifo_full ? LVL_W'(DEPTH) : {1'b0, fifo_counter};
    // Tag the pop that takes the FIFO to empty; a concurrent write still ends the burst here.
    assign pop_is_last = (level == LVL_W'(1));
    assign start_burst = (level >= LVL_W'(BURST_MIN)) | flush |
                         ((tcnt_q == TCNT_W'(TIMEOUT - 1)) & ~fifo_empty);

    assign eff_pop = fifo_read & ~fifo_empty;
    assign m_valid = (skid_occ != 2'd0);
    assign hs      = m_valid & m_ready;
    // Words already in the skid plus the one arriving next cycle, less the one leaving now.
    assign credit  = {1'b0, skid_occ} + {2'b00, inflight_q} - {2'b00, hs};

    // State register and tracking registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= RD_IDLE;
            tcnt_q     <= '0;
            inflight_q <= 1'b0;
            last_tag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tcnt_q     <= tcnt_d;
            inflight_q <= inflight_d;
            last_tag_q <= last_tag_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RD_IDLE: begin
                if (start_burst) begin
                    state_d = RD_DRAIN;
                end
            end
            RD_DRAIN: begin
                // Second term recovers if the FIFO empties without a tagged pop.
                if ((eff_pop & pop_is_last) | (fifo_empty & ~inflight_q)) begin
                    state_d = RD_IDLE;
                end
            end
            default: state_d = RD_IDLE;
        endcase
    end

    // Outputs of the FSM.
    always_comb begin
        fifo_read    = 1'b0;
        drain_active = 1'b0;
        if (state_q == RD_DRAIN) begin
            drain_active = 1'b1;
            fifo_read    = ~fifo_empty & (credit < 3'd2);
        end
    end

    always_comb begin
        inflight_d = eff_pop;
        last_tag_d = eff_pop & pop_is_last;
        tcnt_d     = '0;
        if ((state_q == RD_IDLE) && !fifo_empty && !start_burst) begin
            tcnt_d = tcnt_q + TCNT_W'(1);
        end
    end

    always_comb begin
        skid_in      = '0;
        skid_in.data = fifo_data;
        skid_in.last = last_tag_q;
    end

    fifo_skid_buf u_skid (
        .clk       (clk),
        .reset     (reset),
        .push      (inflight_q),
        .push_word (skid_in),
        .pop       (hs),
        .head      (skid_head),
        .occ       (skid_occ)
    );

    assign m_data = skid_head.data;
    assign m_last = skid_head.last;

endmodule

// File: tb/tb_sync_fifo_rd_adapter.sv
module tb_sync_fifo_rd_adapter;
    import sync_fifo_pkg::*;

    logic        clk = 1'b0;
    logic        rst_ad = 1'b0;
    logic        rst_ff = 1'b0;
    logic        wr_en = 1'b0;
    logic [15:0] wr_data = 16'h0;
    logic        flush = 1'b0;
    logic        m_ready = 1'b1;

    logic        fifo_empty;
    logic        fifo_full;
    logic [4:0]  fifo_counter;
    logic [15:0] fifo_data;
    logic        fifo_read;
    logic        m_valid;
    logic [15:0] m_data;
    logic        m_last;
    logic        drain_active;

    always #5 clk = ~clk;

    sync_fifo #(.WIDTH(16), .CNT_W(5)) u_fifo (
        .clk       (clk),
        .reset     (rst_ff),
        .wr_en_i   (wr_en),
        .wr_data_i (wr_data),
        .rd_en_i   (fifo_read),
        .rd_data_o (fifo_data),
        .empty_o   (fifo_empty),
        .full_o    (fifo_full),
        .counter_o (fifo_counter)
    );

    sync_fifo_rd_adapter #(.WIDTH(16), .CNT_W(5), .BURST_MIN(8), .TIMEOUT(64)) dut (
        .clk          (clk),
        .reset        (rst_ad),
        .fifo_empty   (fifo_empty),
        .fifo_full    (fifo_full),
        .fifo_counter (fifo_counter),
        .fifo_data    (fifo_data),
        .fifo_read    (fifo_read),
        .flush        (flush),
        .m_valid      (m_valid),
        .m_data       (m_data),
        .m_last       (m_last),
        .m_ready      (m_ready),
        .drain_active (drain_active)
    );

    typedef struct packed {
        logic [15:0] data;
        logic        last;
    } exp_t;

    typedef struct {
        int          n;
        logic [15:0] base;
        bit          use_flush;
        int          exp_delay;
    } vec_t;

    exp_t sb_q[$];
    int   n_chk = 0;
    int   n_pass = 0;

    int   cyc = 0;
    int   beats, lasts, first_beat_cyc, last_beat_cyc;
    int   ne_idx = -1;
    int   pop_delay, pop_cyc, valid_cyc, rd_cnt, max_occ;
    bit   pop_seen, valid_seen;
    bit   prev_stall = 1'b0;
    logic [15:0] prev_data;
    logic        prev_last;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor / scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (rst_ad) begin
            prev_stall = 1'b0;
        end else begin
            if (fifo_empty) ne_idx = -1;
            else ne_idx++;
            if (fifo_read) begin
                rd_cnt++;
                if (!pop_seen) begin
                    pop_seen  = 1'b1;
                    pop_delay = ne_idx;
                    pop_cyc   = cyc;
                end
            end
            if (m_valid && !valid_seen) begin
                valid_seen = 1'b1;
                valid_cyc  = cyc;
            end
            if (int'(dut.u_skid.occ) > max_occ) max_occ = int'(dut.u_skid.occ);
            if (prev_stall) begin
                check("stall_hold", 32'({m_valid, m_last, m_data}), 32'({1'b1, prev_last, prev_data}));
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
            if (m_valid && m_ready) begin
                if (beats == 0) first_beat_cyc = cyc;
                last_beat_cyc = cyc;
                beats++;
                if (m_last) lasts++;
                if (sb_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_beat: got data 0x%0h, expected no beat", m_data);
                end else begin
                    e = sb_q.pop_front();
                    check("beat_data", 32'(m_data), 32'(e.data));
                    check("beat_last", 32'(m_last), 32'(e.last));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        beats = 0; lasts = 0; first_beat_cyc = 0; last_beat_cyc = 0;
        pop_seen = 1'b0; valid_seen = 1'b0; pop_delay = -1; pop_cyc = 0; valid_cyc = 0;
        rd_cnt = 0; max_occ = 0;
    endtask

    task automatic write_word(input logic [15:0] d, input bit last);
        exp_t e;
        e.data = d;
        e.last = last;
        wr_en   = 1'b1;
        wr_data = d;
        sb_q.push_back(e);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic wait_beats(input int n, input int bound, input string name);
        int k = 0;
        while (beats < n && k < bound) begin
            tick();
            k++;
        end
        check({name, "_beats"}, 32'(beats), 32'(n));
    endtask

    task automatic check_idle_end(input string name);
        repeat (3) tick();
        check({name, "_drain_off"}, 32'(drain_active), 32'd0);
        check({name, "_fifo_empty"}, 32'(fifo_empty), 32'd1);
        check({name, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
        check({name, "_lasts"}, 32'(lasts), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vt[5];
        int   k;
        vt[0] = '{7,  16'h0001, 1'b0, 64};  // below threshold: idle timeout
        vt[1] = '{8,  16'h0101, 1'b0, 8};   // exactly BURST_MIN
        vt[2] = '{1,  16'h0201, 1'b0, 64};  // single word via timeout
        vt[3] = '{10, 16'h0301, 1'b0, 8};   // writes continue during drain
        vt[4] = '{3,  16'h0401, 1'b1, 3};   // flush forces drain

        // Reset state.
        #1 rst_ad = 1'b1; rst_ff = 1'b1;
        #1;
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_m_last", 32'(m_last), 32'd0);
        check("rst_fifo_read", 32'(fifo_read), 32'd0);
        check("rst_drain", 32'(drain_active), 32'd0);
        repeat (3) tick();
        rst_ad = 1'b0; rst_ff = 1'b0;
        repeat (2) tick();

        // Table-driven bursts with m_ready held high.
        for (int v = 0; v < 5; v++) begin
            clear_stats();
            for (int i = 0; i < vt[v].n; i++) begin
                write_word(vt[v].base + 16'(i), (i == vt[v].n - 1));
            end
            if (vt[v].use_flush) begin
                flush = 1'b1;
                tick();
                flush = 1'b0;
            end
            wait_beats(vt[v].n, vt[v].exp_delay + vt[v].n + 20, "vec");
            check("vec_pop_delay", 32'(pop_delay), 32'(vt[v].exp_delay));
            check("vec_pop_to_valid", 32'(valid_cyc - pop_cyc), 32'd2);
            check("vec_no_bubble", 32'(last_beat_cyc - first_beat_cyc + 1), 32'(vt[v].n));
            check_idle_end("vec");
        end

        // Full FIFO: counter reads 0, level must still start the burst.
        clear_stats();
        rst_ad = 1'b1;
        for (int i = 0; i < 32; i++) write_word(16'h1000 + 16'(i), (i == 31));
        check("full_flag", 32'(fifo_full), 32'd1);
        check("full_counter", 32'(fifo_counter), 32'd0);
        rst_ad = 1'b0;
        @(negedge clk);
        check("full_n1_drain", 32'(drain_active), 32'd0);
        @(negedge clk);
        check("full_n2_drain", 32'(drain_active), 32'd1);
        check("full_n2_read", 32'(fifo_read), 32'd1);
        tick();
        wait_beats(32, 200, "full");
        check_idle_end("full");

        // Backpressure with m_ready pattern 1,0,0,1 while writing 16 words.
        clear_stats();
        k = 0;
        while (k < 400 && beats < 16) begin
            m_ready = ((k % 4) == 0) || ((k % 4) == 3);
            if (k < 16) begin
                exp_t e;
                e.data  = 16'h2000 + 16'(k);
                e.last  = (k == 15);
                wr_en   = 1'b1;
                wr_data = e.data;
                sb_q.push_back(e);
            end else begin
                wr_en = 1'b0;
            end
            tick();
            k++;
        end
        wr_en = 1'b0;
        m_ready = 1'b1;
        check("bp_beats", 32'(beats), 32'd16);
        check("bp_occ_le2", 32'(max_occ <= 2), 32'd1);
        check_idle_end("bp");

        // Reset mid-burst after 4 beats.
        clear_stats();
        for (int i = 0; i < 12; i++) write_word(16'h3000 + 16'(i), (i == 11));
        k = 0;
        while (beats < 4 && k < 100) begin
            @(posedge clk);
            k++;
        end
        #1 rst_ad = 1'b1; rst_ff = 1'b1;
        #1;
        check("mid_rst_beats", 32'(beats), 32'd4);
        check("mid_rst_m_valid", 32'(m_valid), 32'd0);
        check("mid_rst_m_data", 32'(m_data), 32'd0);
        check("mid_rst_m_last", 32'(m_last), 32'd0);
        check("mid_rst_fifo_read", 32'(fifo_read), 32'd0);
        check("mid_rst_drain", 32'(drain_active), 32'd0);
        sb_q.delete();
        repeat (3) tick();
        rst_ad = 1'b0; rst_ff = 1'b0;
        tick();
        clear_stats();
        for (int i = 0; i < 3; i++) write_word(16'h4000 + 16'(i), (i == 2));
        repeat (20) tick();
        check("post_rst_no_read", 32'(rd_cnt), 32'd0);
        check("post_rst_idle", 32'(drain_active), 32'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        wait_beats(3, 40, "post_rst");
        check_idle_end("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
